carry_resolver: RTL
===================

CARRY_RESOLVER -- requirements
Module: carry_resolver

Interface
REQ-001 The block SHALL use the parameters, types and widths from package PARAMS_BN254_d0: ADD_DIV, fp_div4_t, redundant_poly_L1, M_tilde12_t.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  din valid.
REQ-005 in_ready  output  1  block can accept din.
REQ-006 din  input  redundant_poly_L1  ADD_DIV redundant limbs, e.g. a cmul output.
REQ-007 out_valid  output  1  dout valid.
REQ-008 out_ready  input  1  consumer accepts dout.
REQ-009 dout  output  M_tilde12_t  canonical integer: sum over i of din[i] << (i*S).
REQ-010 busy  output  1  high in RUN or DONE.

Function
REQ-011 Definitions: S = $bits(fp_div4_t) is the limb stride; LW = $bits(din[0]) is the limb width, with LW >= S; CW = LW-S+1 is the carry width.
REQ-012 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE: in_ready=1; when in_valid && in_ready, the block SHALL latch din into a limb register, clear carry and limb index k, and go to RUN.
REQ-014 RUN, one limb per cycle:
  - t = limb[k] + carry, computed LW+1 bits wide;
  - result chunk k = t[S-1:0];
  - carry = t >> S;
  - k increments.
REQ-015 After the cycle with k = ADD_DIV-1, the final carry SHALL be placed at bit ADD_DIV*S, the result SHALL be truncated to $bits(M_tilde12_t), and the state SHALL go to DONE.
REQ-016 DONE: out_valid=1 and dout stable; on out_ready the state SHALL go to IDLE. There is no same-cycle accept of new input.
REQ-017 Latency SHALL be ADD_DIV+1 cycles from the accept edge to out_valid. Throughput SHALL be one result per ADD_DIV+2 cycles minimum.
REQ-018 in_ready SHALL be 0 in RUN and DONE. din and in_valid SHALL be ignored outside IDLE.
REQ-019 If out_ready is held low, DONE SHALL persist indefinitely with dout unchanged.
REQ-020 The carry register SHALL be CW bits wide and SHALL never overflow, including when every limb is at its maximum value.
REQ-021 When the true value is at least 2^$bits(M_tilde12_t), dout SHALL hold the value modulo 2^$bits(M_tilde12_t).

Reset
REQ-022 On rstn=0, asynchronously: state=IDLE, k=0, carry=0, dout=0, out_valid=0, busy=0, in_ready=1 (in_ready=1 once in IDLE).
REQ-023 Reset asserted in RUN or DONE SHALL discard the operation in progress. No out_valid pulse SHALL follow reset release.

Configuration
REQ-024 Macro CARRY_RESOLVER_OVF_EN: when defined, the block SHALL add output port ovf (1 bit, reset 0). ovf SHALL be valid with out_valid and SHALL be high when any bit at or above $bits(M_tilde12_t) of the untruncated result is nonzero.
REQ-025 Without CARRY_RESOLVER_OVF_EN, the ovf port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-026 CW and a typedef carry_t SHALL be added to PARAMS_BN254_d0. The state enum SHALL stay local to the module.
REQ-027 One sub-module, limb_add, SHALL perform the combinational limb + carry add and split into (chunk, carry_out).
REQ-028 No other hierarchy SHALL be used.

Verification
REQ-029 din all zero, accept at cycle 0 -> out_valid at cycle ADD_DIV+1, dout=0, ovf=0.
REQ-030 din[0]=2^S+5, other limbs 0 -> dout=2^S+5; the carry passes into chunk 1.
REQ-031 Every limb = 2^LW-1 -> dout equals the golden sum mod 2^$bits(M_tilde12_t); ovf=1 if that sum reaches 2^$bits(M_tilde12_t).
REQ-032 out_ready low for 5 cycles in DONE -> dout and out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-033 rstn pulsed low at RUN cycle 2 -> out_valid=0 and in_ready=1 immediately; the next input converts correctly.
REQ-034 1e5 random din fed from cmul outputs with modes 0..6 and random out_ready -> each dout equals the golden shift-and-sum of din.

Source files
------------

// File: rtl/carry_resolver_pkg.sv
// PARAMS_BN254_d0: shared widths and types for the BN254 carry resolver slice.
package PARAMS_BN254_d0;
    localparam int ADD_DIV = 4;
    typedef logic [63:0] fp_div4_t;
    localparam int S = $bits(fp_div4_t);
    localparam int LW = 66;
    typedef logic [ADD_DIV-1:0][LW-1:0] redundant_poly_L1;
    typedef logic [255:0] M_tilde12_t;
    localparam int MW = $bits(M_tilde12_t);
    // Wide enough that limb + carry never carries out of it, even with all-ones limbs.
    localparam int CW = LW - S + 1;
    typedef logic [CW-1:0] carry_t;
endpackage

// File: rtl/carry_resolver_limb_add.sv
// limb_add: one redundant limb plus incoming carry, split into a stride-wide chunk and carry out.
module limb_add
    import PARAMS_BN254_d0::*;
(
    input  logic [LW-1:0] limb,
    input  carry_t        cin,
    output fp_div4_t      chunk,
    output carry_t        cout
);
    logic [LW:0] t;
    assign t = {1'b0, limb} + {{S{1'b0}}, cin};
    assign chunk = t[S-1:0];
    assign cout = t[LW:S];
endmodule

// File: rtl/carry_resolver.sv
// carry_resolver: serially resolves ADD_DIV redundant limbs into one canonical integer.
// Optional ovf output enabled by CARRY_RESOLVER_OVF_EN.
module carry_resolver
    import PARAMS_BN254_d0::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  redundant_poly_L1 din,
    output logic             out_valid,
    input  logic             out_ready,
    output M_tilde12_t       dout,
    output logic             busy
`ifdef CARRY_RESOLVER_OVF_EN
    ,
    output logic             ovf
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int KW = $clog2(ADD_DIV);
    state_t state, state_nx;
    redundant_poly_L1 limbs;
    carry_t carry, cout;
    logic [KW-1:0] k;
    logic [ADD_DIV*S-1:0] res, res_nx;
    fp_div4_t chunk;
    logic last;
    limb_add u_add (
        .limb  (limbs[k]),
        .cin   (carry),
        .chunk (chunk),
        .cout  (cout)
    );
    assign last = k == KW'(ADD_DIV - 1);
    always_comb begin
        res_nx = res;
        res_nx[k*S +: S] = chunk;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                                   (out_ready ? IDLE : DONE);
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
        busy = state != IDLE;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            limbs <= '0;
            carry <= '0;
            k <= '0;
            res <= '0;
            dout <= '0;
        end else if (state == IDLE && in_valid) begin
            limbs <= din;
            carry <= '0;
            k <= '0;
            res <= '0;
        end else if (state == RUN) begin
            res <= res_nx;
            carry <= cout;
            k <= k + 1'b1;
            if (last) dout <= M_tilde12_t'({cout, res_nx});
        end
`ifdef CARRY_RESOLVER_OVF_EN
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) ovf <= 1'b0;
        else if (state == RUN && last) ovf <= |({cout, res_nx} >> MW);
`endif
endmodule
